// File: rtl/freq_sweep_controller.sv
// Frequency sweep sequencer: launches one measurement per point and captures amp/phase into a table.
// Optional peak tracking is enabled by defining SWEEP_PEAK_TRACK_EN.
module freq_sweep_controller #(
  parameter int unsigned FREQ_W  = 16,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned AMP_W   = 12,
  parameter int unsigned PHASE_W = 12,
  parameter int unsigned DELAY_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sweep_start,
  input  logic [FREQ_W-1:0]  f_start,
  input  logic [FREQ_W-1:0]  f_step,
  input  logic [ADDR_W:0]    n_points,
  input  logic [DELAY_W-1:0] settle_us,
  output logic               unit_start,
  output logic [FREQ_W-1:0]  unit_freq,
  output logic [DELAY_W-1:0] unit_delay_us,
  input  logic               unit_done,
  input  logic [AMP_W-1:0]   unit_amp,
  input  logic [PHASE_W-1:0] unit_phase,
  output logic               busy,
  output logic               sweep_done,
  output logic [ADDR_W:0]    point_cnt,
`ifdef SWEEP_PEAK_TRACK_EN
  output logic [AMP_W-1:0]   peak_amp,
  output logic [FREQ_W-1:0]  peak_freq,
  output logic [ADDR_W-1:0]  peak_idx,
`endif
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [AMP_W-1:0]   rd_amp,
  output logic [PHASE_W-1:0] rd_phase
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef struct packed {
    logic [AMP_W-1:0]   amp;
    logic [PHASE_W-1:0] phase;
  } point_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_STORE,
    S_FINISH
  } state_t;

  state_t             state_q, state_d;
  logic [FREQ_W-1:0]  f_step_q, f_step_d;
  logic [CNT_W-1:0]   n_points_q, n_points_d;
  logic [CNT_W-1:0]   point_cnt_d;
  logic [FREQ_W-1:0]  unit_freq_d;
  logic [DELAY_W-1:0] unit_delay_d;
  logic               busy_d, unit_start_d, sweep_done_d;
  logic               done_q;
  logic               done_rise;
  point_t             cap_q, cap_d;
  logic               wr_en;
  logic [FREQ_W:0]    freq_sum;
  logic [CNT_W-1:0]   cnt_inc;
  point_t             rd_d;
  point_t             mem [DEPTH];

`ifdef SWEEP_PEAK_TRACK_EN
  logic [AMP_W-1:0]   peak_amp_d;
  logic [FREQ_W-1:0]  peak_freq_d;
  logic [ADDR_W-1:0]  peak_idx_d;
`endif

  assign done_rise = unit_done & ~done_q;
  assign freq_sum  = {1'b0, unit_freq} + {1'b0, f_step_q};
  assign cnt_inc   = point_cnt + CNT_W'(1);

  // Next-state and next-register values
  always_comb begin
    state_d      = state_q;
    f_step_d     = f_step_q;
    n_points_d   = n_points_q;
    point_cnt_d  = point_cnt;
    unit_freq_d  = unit_freq;
    unit_delay_d = unit_delay_us;
    busy_d       = busy;
    unit_start_d = 1'b0;
    sweep_done_d = 1'b0;
    cap_d        = cap_q;
    wr_en        = 1'b0;
`ifdef SWEEP_PEAK_TRACK_EN
    peak_amp_d   = peak_amp;
    peak_freq_d  = peak_freq;
    peak_idx_d   = peak_idx;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (sweep_start) begin
          f_step_d     = f_step;
          n_points_d   = n_points;
          unit_delay_d = settle_us;
          unit_freq_d  = f_start;
          point_cnt_d  = '0;
          busy_d       = 1'b1;
`ifdef SWEEP_PEAK_TRACK_EN
          peak_amp_d   = '0;
          peak_freq_d  = '0;
          peak_idx_d   = '0;
`endif
          if (n_points == '0) begin
            state_d = S_FINISH;
          end else begin
            state_d      = S_LAUNCH;
            unit_start_d = 1'b1;
          end
        end
      end
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT: begin
        if (done_rise) begin
          cap_d.amp   = unit_amp;
          cap_d.phase = unit_phase;
          state_d     = S_STORE;
        end
      end
      S_STORE: begin
        wr_en       = 1'b1;
        point_cnt_d = cnt_inc;
        unit_freq_d = freq_sum[FREQ_W] ? '1 : freq_sum[FREQ_W-1:0];
`ifdef SWEEP_PEAK_TRACK_EN
        if (cap_q.amp > peak_amp) begin
          peak_amp_d  = cap_q.amp;
          peak_freq_d = unit_freq;
          peak_idx_d  = point_cnt[ADDR_W-1:0];
        end
`endif
        if (cnt_inc == n_points_q) begin
          state_d = S_FINISH;
        end else begin
          state_d      = S_LAUNCH;
          unit_start_d = 1'b1;
        end
      end
      S_FINISH: begin
        busy_d       = 1'b0;
        sweep_done_d = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Addresses at or beyond point_cnt read as zero regardless of RAM contents
  always_comb begin
    rd_d = '0;
    if ({1'b0, rd_addr} < point_cnt) rd_d = mem[rd_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      f_step_q      <= '0;
      n_points_q    <= '0;
      point_cnt     <= '0;
      unit_freq     <= '0;
      unit_delay_us <= '0;
      busy          <= 1'b0;
      unit_start    <= 1'b0;
      sweep_done    <= 1'b0;
      done_q        <= 1'b0;
      cap_q         <= '0;
      rd_amp        <= '0;
      rd_phase      <= '0;
`ifdef SWEEP_PEAK_TRACK_EN
      peak_amp      <= '0;
      peak_freq     <= '0;
      peak_idx      <= '0;
`endif
    end else begin
      state_q       <= state_d;
      f_step_q      <= f_step_d;
      n_points_q    <= n_points_d;
      point_cnt     <= point_cnt_d;
      unit_freq     <= unit_freq_d;
      unit_delay_us <= unit_delay_d;
      busy          <= busy_d;
      unit_start    <= unit_start_d;
      sweep_done    <= sweep_done_d;
      done_q        <= unit_done;
      cap_q         <= cap_d;
      rd_amp        <= rd_d.amp;
      rd_phase      <= rd_d.phase;
`ifdef SWEEP_PEAK_TRACK_EN
      peak_amp      <= peak_amp_d;
      peak_freq     <= peak_freq_d;
      peak_idx      <= peak_idx_d;
`endif
    end
  end

  // Result table: not reset, written in STORE (read above sees pre-write data)
  always_ff @(posedge clk) begin
    if (wr_en) mem[point_cnt[ADDR_W-1:0]] <= cap_q;
  end

endmodule
